// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS multiply/divide unit. It owns the HI/LO registers.
//   clk, reset   rising-edge clock and synchronous active-high reset
//   start, op    begin MULT(00) / MULTU(01) / DIV(10) / DIVU(11)
//   Data1, Data2 rs / rt operands, sampled only when start is accepted
//   hi_we, lo_we MTHI/MTLO strobes with wdata, honoured only when idle
//   busy         operation in progress
//   done         one-cycle pulse when HI/LO take a result
//   div_by_zero  last divide had a zero divisor
//   hi, lo       architectural HI/LO registers
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Data1,
  input  logic [WIDTH-1:0] Data2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t               state;
  logic                 is_div;
  logic                 neg_q;      // result (product or quotient) must be negated
  logic                 neg_r;      // remainder takes the dividend's sign
  logic                 dbz_pend;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     opnd;       // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc;        // multiply: {partial, multiplier}; divide: {remainder, quotient}

  logic                 signed_op;
  logic                 neg_a, neg_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  always_comb begin
    signed_op = ~op[0];
    neg_a     = signed_op & Data1[WIDTH-1];
    neg_b     = signed_op & Data2[WIDTH-1];
    mag_a     = neg_a ? ('0 - Data1) : Data1;
    mag_b     = neg_b ? ('0 - Data2) : Data2;

    // Shift-add: add multiplicand into the upper half when the multiplier LSB is set,
    // then shift the whole accumulator right, carry included.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: the dividend shifts out of the low half into the remainder
    // while quotient bits shift in from the right.
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd};
    if (div_trial[WIDTH])
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    prod_fix  = neg_q ? ('0 - acc) : acc;
    quo_fix   = neg_q ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix   = neg_r ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_pend    <= 1'b0;
      cnt         <= '0;
      opnd        <= '0;
      acc         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div      <= op[1];
            neg_q       <= neg_a ^ neg_b;
            neg_r       <= neg_a;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            if (op[1] && Data2 == '0) begin
              // Zero divisor: park the raw dividend and all-ones quotient for FINISH.
              dbz_pend <= 1'b1;
              acc      <= {Data1, {WIDTH{1'b1}}};
              state    <= FINISH;
            end else begin
              dbz_pend <= 1'b0;
              opnd     <= op[1] ? mag_b : mag_a;
              acc      <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
              state    <= RUN;
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1))
            state <= FINISH;
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          if (dbz_pend) begin
            hi          <= acc[2*WIDTH-1:WIDTH];
            lo          <= acc[WIDTH-1:0];
            div_by_zero <= 1'b1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and randomised checks of mult_div_unit at WIDTH=32 and WIDTH=8.
module tb_mult_div_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          bcnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;

  logic        start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] d1, d2, wdata;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  logic        start8, hwe8, lwe8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wd8;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .Data1(d1), .Data2(d2),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(dbz), .hi(hi), .lo(lo)
  );

  mult_div_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .Data1(a8), .Data2(b8),
    .hi_we(hwe8), .lo_we(lwe8), .wdata(wd8), .busy(busy8), .done(done8),
    .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  function automatic exp_t mk(logic [31:0] h, logic [31:0] l, logic z, int n);
    exp_t e;
    e.hi = h; e.lo = l; e.dbz = z; e.bcnt = n;
    return e;
  endfunction

  // Reference behaviour for the 32-bit unit, written with native SV arithmetic.
  function automatic exp_t model(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    longint          sp;
    longint unsigned up;
    int              q, r;
    if (o[1] && b == 32'd0) return mk(a, 32'hFFFF_FFFF, 1'b1, 1);
    case (o)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return mk(sp[63:32], sp[31:0], 1'b0, 33);
      end
      2'b01: begin
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        return mk(up[63:32], up[31:0], 1'b0, 33);
      end
      2'b10: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return mk(32'd0, 32'h8000_0000, 1'b0, 33);
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return mk(r, q, 1'b0, 33);
      end
      default: return mk(a % b, a / b, 1'b0, 33);
    endcase
  endfunction

  function automatic logic o_busy(bit s);
    return s ? busy8 : busy;
  endfunction
  function automatic logic o_done(bit s);
    return s ? done8 : done;
  endfunction
  function automatic logic o_dbz(bit s);
    return s ? dbz8 : dbz;
  endfunction
  function automatic logic [31:0] o_hi(bit s);
    return s ? {24'd0, hi8} : hi;
  endfunction
  function automatic logic [31:0] o_lo(bit s);
    return s ? {24'd0, lo8} : lo;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: presents start for one edge, then scrambles the operands.
  task automatic issue(bit s, logic [1:0] o, logic [31:0] a, logic [31:0] b);
    if (s) begin
      start8 = 1'b1; op8 = o; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start = 1'b1; op = o; d1 = a; d2 = b;
    end
    @(negedge clk);
    start = 1'b0; start8 = 1'b0;
    d1 = $urandom; d2 = $urandom; op = 2'($urandom_range(0, 3));
    a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom_range(0, 3));
  endtask

  // Waits for done (bounded), optionally injecting an ignored start/MTHI/MTLO pulse.
  task automatic finish_op(bit s, string tag, int inject);
    int   n = 0;
    bit   seen = 1'b0;
    exp_t e;
    for (int i = 0; i < 100; i++) begin
      if (o_done(s)) begin
        seen = 1'b1;
        break;
      end
      if (o_busy(s)) n++;
      if (inject >= 0) begin
        start = (i == inject); hi_we = (i == inject); lo_we = (i == inject);
        if (i == inject) begin
          op = 2'b11; d1 = 32'h0000_0055; d2 = 32'd3; wdata = 32'hDEAD_BEEF;
        end
      end
      @(negedge clk);
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (sb.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_hi"}, 64'(o_hi(s)), 64'(e.hi));
    check({tag, "_lo"}, 64'(o_lo(s)), 64'(e.lo));
    check({tag, "_dbz"}, 64'(o_dbz(s)), 64'(e.dbz));
    check({tag, "_busy_cycles"}, 64'(n), 64'(e.bcnt));
    check({tag, "_busy_low"}, 64'(o_busy(s)), 64'd0);
  endtask

  initial begin
    int          dn;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    reset = 1'b1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; op = 2'b00; d1 = '0; d2 = '0; wdata = '0;
    start8 = 1'b0; hwe8 = 1'b0; lwe8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0; wd8 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(dbz), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // MULT -3 * 7, then done must be a single pulse
    sb.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33));
    issue(0, 2'b00, 32'hFFFF_FFFD, 32'd7);
    finish_op(0, "mult_neg", -1);
    @(negedge clk);
    check("mult_neg_done_single", 64'(done), 64'd0);

    // Back-to-back: each start issued in the done cycle
    sb.push_back(mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33));
    issue(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op(0, "multu_max", -1);
    sb.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33));
    issue(0, 2'b10, 32'hFFFF_FFF9, 32'd2);
    finish_op(0, "div_neg", -1);
    sb.push_back(mk(32'd2, 32'd14, 1'b0, 33));
    issue(0, 2'b11, 32'd100, 32'd7);
    finish_op(0, "divu", -1);

    // Divide by zero, flag held while idle, cleared by the next accepted start
    sb.push_back(mk(32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1));
    issue(0, 2'b11, 32'd100, 32'd0);
    finish_op(0, "divu_zero", -1);
    repeat (2) @(negedge clk);
    check("dbz_held", 64'(dbz), 64'd1);
    sb.push_back(mk(32'd0, 32'h8000_0000, 1'b0, 33));
    issue(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("dbz_cleared_on_start", 64'(dbz), 64'd0);
    finish_op(0, "div_ovf", -1);

    // Start/MTHI/MTLO while busy are ignored; then idle writes land
    sb.push_back(mk(32'd0, 32'd30, 1'b0, 33));
    issue(0, 2'b00, 32'd5, 32'd6);
    finish_op(0, "mult_ignore", 9);
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h1234);
    check("mtlo_hi_kept", 64'(hi), 64'd0);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_both_hi", 64'(hi), 64'hCAFE_F00D);
    check("mthi_both_lo", 64'(lo), 64'hCAFE_F00D);

    // Reset in the middle of a divide
    issue(0, 2'b10, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("midrst_no_done", 64'(dn), 64'd0);
    sb.push_back(mk(32'd0, 32'd6, 1'b0, 33));
    issue(0, 2'b00, 32'd2, 32'd3);
    finish_op(0, "mult_after_rst", -1);

    // WIDTH=8 instance
    sb.push_back(mk(32'h40, 32'h00, 1'b0, 9));
    issue(1, 2'b00, 32'h80, 32'h80);
    finish_op(1, "w8_mult", -1);
    sb.push_back(mk(32'hFF, 32'hD6, 1'b0, 9));
    issue(1, 2'b10, 32'h81, 32'h03);
    finish_op(1, "w8_div", -1);

    // Randomised operations against the reference model
    for (int k = 0; k < 8; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      if (k == 3) rb = 32'hFFFF_FFFF;
      sb.push_back(model(ro, ra, rb));
      issue(0, ro, ra, rb);
      finish_op(0, $sformatf("rand%0d_op%0d", k, ro), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Parametrised iterative multiply/divide unit for the MIPS datapath. It is the sequential companion to the single-cycle ALU and executes MULT, MULTU, DIV and DIVU into architectural HI/LO registers. It uses a start/busy/done handshake so the pipeline can stall on MFHI/MFLO. It also services MTHI/MTLO writes.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; must be >= 4.
CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request to begin an operation; sampled on the rising edge
op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
Data1  input  WIDTH  multiplicand or dividend (rs)
Data2  input  WIDTH  multiplier or divisor (rt)
hi_we  input  1  MTHI write strobe
lo_we  input  1  MTLO write strobe
wdata  input  WIDTH  data for MTHI/MTLO
busy  output  1  operation in progress
done  output  1  one-cycle pulse when HI/LO take a result
div_by_zero  output  1  last DIV/DIVU had Data2==0; held until the next accepted start
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset, synchronous on clk edge with reset=1: busy=0, done=0, div_by_zero=0, hi=0, lo=0, FSM=IDLE. Reset during RUN aborts the operation and discards all partial state.
- FSM has three states: IDLE, RUN, FINISH.
- IDLE, start=1:
  - Latch op, the operand magnitudes (signed ops only) and result-sign flags. Counter=0, div_by_zero=0. Go to RUN.
  - busy=1 from the next cycle.
  - hi_we/lo_we in the same cycle are ignored; start wins.
- IDLE, start=0: hi_we loads hi<=wdata and lo_we loads lo<=wdata. Both may fire in the same cycle.
- RUN performs one iteration per edge for exactly WIDTH edges:
  - Multiply: shift-add over unsigned magnitudes, 2*WIDTH-bit product.
  - Divide: restoring shift-subtract over unsigned magnitudes; quotient and remainder are WIDTH bits each.
  - After iteration WIDTH, go to FINISH.
- FINISH, one cycle:
  - Apply sign correction. Signed multiply negates the 2*WIDTH product when the operand signs differ. Signed divide negates the quotient when the signs differ; the remainder takes the dividend's sign.
  - Write hi/lo (multiply: hi=upper half, lo=lower half; divide: lo=quotient, hi=remainder).
  - done=1 for that one cycle; busy=0 on the following edge; return to IDLE.
- Latency: start accepted at edge E0; hi/lo updated and done=1 after edge E(WIDTH+1); busy high for WIDTH+1 cycles.
- Divide by zero (DIV/DIVU with Data2==0):
  - Skip RUN and go IDLE->FINISH, so busy=1 for exactly 1 cycle.
  - lo = all ones, hi = Data1 unmodified, div_by_zero=1.
- Signed overflow, DIV of most-negative by -1: lo = most-negative value, hi = 0. No flag.
- While busy: start, hi_we and lo_we are ignored. hi/lo keep their old values until FINISH; no intermediate values are ever visible.
- Operands are sampled only at acceptance; later changes on Data1/Data2/op have no effect.
- A start in the cycle where done=1 is accepted normally; the FSM is in IDLE on that edge.

Test Plan:
- WIDTH=32, MULT Data1=0xFFFFFFFD (-3), Data2=7 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses exactly once, busy high 33 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
- DIVU Data1=100, Data2=0 -> busy 1 cycle, lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1; next start clears it; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULT 5x6; at cycle 10 pulse start with other operands plus hi_we/lo_we -> all ignored, final hi=0, lo=30; afterwards idle lo_we with wdata=0x1234 -> lo=0x1234.
- Start DIV, assert reset at cycle 10 -> next edge busy=0, done=0, hi=lo=0; no done pulse afterwards; a new MULT 2x3 then completes with lo=6.
- WIDTH=8 instance: MULT 0x80 x 0x80 -> hi=0x40, lo=0x00 after 9 cycles; DIV 0x81/0x03 -> lo=0xD6, hi=0xFF.
